draw_bird: RTL and testbench
============================

DRAW_BIRD -- requirements
Module: draw_bird

Interface
REQ-001 Parameter WIDTH, default 34, bird width in pixels.
REQ-002 Parameter HEIGHT, default 24, bird height in pixels.
REQ-003 Parameter BODY_COLOR, default 12'hFC0, body colour (RGB444).
REQ-004 Parameter WING_COLOR, default 12'hFFF, raised-wing colour (RGB444).
REQ-005 Parameter FLAP_FRAMES, default 8, frames per wing toggle; legal range 1..255.
REQ-006 clk  in  1  pixel clock, 40 MHz; single clock domain.
REQ-007 rst  in  1  reset, synchronous, active-high.
REQ-008 hcount_in, vcount_in  in  11 each  pixel position from vga_timing or the upstream draw stage.
REQ-009 hsync_in, hblnk_in, vsync_in, vblnk_in  in  1 each  timing strobes from upstream.
REQ-010 rgb_in  in  12  upstream pixel colour.
REQ-011 xpos, ypos  in  11 each  requested bird top-left corner.
REQ-012 pos_valid  in  1  one-cycle strobe; xpos/ypos are sampled when it is high.
REQ-013 hcount_out, vcount_out, hsync_out, hblnk_out, vsync_out, vblnk_out  out  11/11/1/1/1/1  inputs delayed by 2 cycles.
REQ-014 rgb_out  out  12  composited pixel colour.
REQ-015 pos_pending  out  1  high while a sampled position waits for the next frame boundary.

Function
REQ-016 All timing outputs SHALL equal the matching inputs delayed by exactly 2 clk cycles; rgb_out SHALL be aligned with them.
REQ-017 A frame boundary is a rising edge of vblnk_in, detected with a registered copy of vblnk_in.
REQ-018 pos_valid=1 SHALL load xpos/ypos into pending registers and set pos_pending; a later pos_valid before the boundary overwrites the pending value (last one wins).
REQ-019 At a frame boundary with pos_pending=1, pending values SHALL move into the active registers and pos_pending SHALL clear.
REQ-020 If pos_valid and a frame boundary occur in the same cycle, the incoming xpos/ypos SHALL go straight into the active registers and pos_pending SHALL end low.
REQ-021 Active position SHALL never change outside a frame boundary, so a frame is never torn.
REQ-022 A pixel is inside the bird when xa <= hcount_in <= xa+WIDTH-1 and ya <= vcount_in <= ya+HEIGHT-1, with hblnk_in=0 and vblnk_in=0.
REQ-023 The bounds SHALL be computed at 12 bits so they do not wrap; a bird partly off-screen is clipped, never wrapped to column/row 0.
REQ-024 Flap counter, 8 bits: increments at each frame boundary; on reaching FLAP_FRAMES-1 it resets to 0 and toggles wing_up.
REQ-025 Wing region: relative row 10..15 and relative column 4..13 inside the bird.
REQ-026 Inside the wing region with wing_up=1, rgb_out SHALL be WING_COLOR.
REQ-027 Elsewhere inside the bird, rgb_out SHALL be BODY_COLOR.
REQ-028 Outside the bird, rgb_out SHALL equal rgb_in delayed by 2 cycles.
REQ-029 Pipeline: stage 1 registers the compare results and the relative row/column; stage 2 registers the colour select.

Reset
REQ-030 While rst=1 at a clk edge, all outputs SHALL go to 0, including rgb_out=12'h000 and pos_pending=0.
REQ-031 rst SHALL clear the pipeline, the flap counter and wing_up, and SHALL set the active position to (0,0).
REQ-032 Reset mid-frame SHALL discard any pending position; normal output resumes 2 cycles after rst falls.

Configuration
REQ-033 Macro DRAW_BIRD_OUTLINE_EN:
- Defined: in-bird pixels on relative row 0, row HEIGHT-1, column 0 or column WIDTH-1 SHALL be 12'h000 (1-pixel black outline); the outline overrides wing and body colour.
- Undefined: no outline logic is compiled and REQ-026/027 apply unchanged.

Verification
REQ-034 Pass-through: rgb_in=12'h0AF, bird off-screen at (1900,700) -> rgb_out=12'h0AF and all timing outputs equal the inputs 2 cycles later.
REQ-035 Draw: active position (100,300) -> pixel (100,300) is BODY_COLOR (12'h000 with the outline macro); (133,323) is inside; (134,300) and (100,324) equal rgb_in.
REQ-036 Deferred update: pos_valid with (200,200) mid-frame -> pos_pending=1 and the current frame still draws at (100,300); from the next frame the bird is at (200,200) and pos_pending=0.
REQ-037 Collision: pos_valid in the same cycle as the vblnk_in rise -> the new position takes effect that frame and pos_pending stays 0.
REQ-038 Flap: FLAP_FRAMES=2 -> wing_up toggles every 2 frame boundaries; pixel (x+5,y+12) alternates WING_COLOR/BODY_COLOR.
REQ-039 Clip/reset: xpos=2040 -> no pixel drawn at hcount 0..30; asserting rst mid-line -> rgb_out=0 and pos_pending=0 on the next edge.

Source files
------------

// File: rtl/draw_bird.sv
// Sprite stage: overlays a flapping bird on the incoming pixel stream with a
// 2-cycle pipeline. Define DRAW_BIRD_OUTLINE_EN to add a 1-pixel black outline.
module draw_bird #(
   parameter int          WIDTH       = 34,
   parameter int          HEIGHT      = 24,
   parameter logic [11:0] BODY_COLOR  = 12'hFC0,
   parameter logic [11:0] WING_COLOR  = 12'hFFF,
   parameter int          FLAP_FRAMES = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [10:0] hcount_in,
   input  logic [10:0] vcount_in,
   input  logic        hsync_in,
   input  logic        hblnk_in,
   input  logic        vsync_in,
   input  logic        vblnk_in,
   input  logic [11:0] rgb_in,
   input  logic [10:0] xpos,
   input  logic [10:0] ypos,
   input  logic        pos_valid,
   output logic [10:0] hcount_out,
   output logic [10:0] vcount_out,
   output logic        hsync_out,
   output logic        hblnk_out,
   output logic        vsync_out,
   output logic        vblnk_out,
   output logic [11:0] rgb_out,
   output logic        pos_pending
);

   logic        vblnk_prev_q;
   logic [10:0] pend_x_q, pend_x_d, pend_y_q, pend_y_d;
   logic [10:0] act_x_q, act_x_d, act_y_q, act_y_d;
   logic        pos_pending_q, pos_pending_d;
   logic [7:0]  flap_cnt_q, flap_cnt_d;
   logic        wing_up_q, wing_up_d;
   logic        frame_edge;

   // Timing bundle {hcount, vcount, hsync, hblnk, vsync, vblnk}
   logic [25:0] tim_s1_q, tim_s2_q;
   logic [11:0] rgb_s1_q, rgb_s2_q, rgb_s2_d;
   logic        in_bird_q, in_bird_d;
   logic [10:0] rel_col_q, rel_col_d, rel_row_q, rel_row_d;
   logic [11:0] h12, v12, x_lo, x_hi, y_lo, y_hi;
   logic        wing_zone;

   assign frame_edge = vblnk_in & ~vblnk_prev_q;

   // Position and flap bookkeeping: active position only moves on a frame edge
   always_comb begin
      pend_x_d      = pend_x_q;
      pend_y_d      = pend_y_q;
      act_x_d       = act_x_q;
      act_y_d       = act_y_q;
      pos_pending_d = pos_pending_q;
      flap_cnt_d    = flap_cnt_q;
      wing_up_d     = wing_up_q;
      if (pos_valid && frame_edge) begin
         act_x_d       = xpos;
         act_y_d       = ypos;
         pos_pending_d = 1'b0;
      end else if (pos_valid) begin
         pend_x_d      = xpos;
         pend_y_d      = ypos;
         pos_pending_d = 1'b1;
      end else if (frame_edge && pos_pending_q) begin
         act_x_d       = pend_x_q;
         act_y_d       = pend_y_q;
         pos_pending_d = 1'b0;
      end
      if (frame_edge) begin
         if (flap_cnt_q == 8'(FLAP_FRAMES - 1)) begin
            flap_cnt_d = 8'd0;
            wing_up_d  = ~wing_up_q;
         end else begin
            flap_cnt_d = flap_cnt_q + 8'd1;
         end
      end
   end

   // Bounds widened to 12 bits so a bird near 2047 clips instead of wrapping
   always_comb begin
      h12       = {1'b0, hcount_in};
      v12       = {1'b0, vcount_in};
      x_lo      = {1'b0, act_x_q};
      y_lo      = {1'b0, act_y_q};
      x_hi      = x_lo + 12'(WIDTH - 1);
      y_hi      = y_lo + 12'(HEIGHT - 1);
      in_bird_d = (h12 >= x_lo) && (h12 <= x_hi) && (v12 >= y_lo) && (v12 <= y_hi)
                  && !hblnk_in && !vblnk_in;
      rel_col_d = hcount_in - act_x_q;
      rel_row_d = vcount_in - act_y_q;
   end

   assign wing_zone = (rel_row_q >= 11'd10) && (rel_row_q <= 11'd15) &&
                      (rel_col_q >= 11'd4)  && (rel_col_q <= 11'd13);

   always_comb begin
      rgb_s2_d = rgb_s1_q;
      if (in_bird_q) begin
`ifdef DRAW_BIRD_OUTLINE_EN
         if (rel_row_q == 11'd0 || rel_row_q == 11'(HEIGHT - 1) ||
             rel_col_q == 11'd0 || rel_col_q == 11'(WIDTH - 1))
            rgb_s2_d = 12'h000;
         else if (wing_zone && wing_up_q)
            rgb_s2_d = WING_COLOR;
         else
            rgb_s2_d = BODY_COLOR;
`else
         if (wing_zone && wing_up_q)
            rgb_s2_d = WING_COLOR;
         else
            rgb_s2_d = BODY_COLOR;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         vblnk_prev_q  <= 1'b0;
         pend_x_q      <= '0;
         pend_y_q      <= '0;
         act_x_q       <= '0;
         act_y_q       <= '0;
         pos_pending_q <= 1'b0;
         flap_cnt_q    <= '0;
         wing_up_q     <= 1'b0;
         tim_s1_q      <= '0;
         tim_s2_q      <= '0;
         rgb_s1_q      <= '0;
         rgb_s2_q      <= '0;
         in_bird_q     <= 1'b0;
         rel_col_q     <= '0;
         rel_row_q     <= '0;
      end else begin
         vblnk_prev_q  <= vblnk_in;
         pend_x_q      <= pend_x_d;
         pend_y_q      <= pend_y_d;
         act_x_q       <= act_x_d;
         act_y_q       <= act_y_d;
         pos_pending_q <= pos_pending_d;
         flap_cnt_q    <= flap_cnt_d;
         wing_up_q     <= wing_up_d;
         tim_s1_q      <= {hcount_in, vcount_in, hsync_in, hblnk_in, vsync_in, vblnk_in};
         tim_s2_q      <= tim_s1_q;
         rgb_s1_q      <= rgb_in;
         rgb_s2_q      <= rgb_s2_d;
         in_bird_q     <= in_bird_d;
         rel_col_q     <= rel_col_d;
         rel_row_q     <= rel_row_d;
      end
   end

   assign {hcount_out, vcount_out, hsync_out, hblnk_out, vsync_out, vblnk_out} = tim_s2_q;
   assign rgb_out     = rgb_s2_q;
   assign pos_pending = pos_pending_q;

endmodule

// File: tb/tb_draw_bird.sv
// Bench for draw_bird: directed pixel vectors, expected outputs queued by the
// driver and checked by an independent monitor two cycles later.
module tb_draw_bird;

   localparam logic [11:0] BODY = 12'hFC0;
   localparam logic [11:0] WING = 12'hFFF;
`ifdef DRAW_BIRD_OUTLINE_EN
   localparam logic [11:0] EDGE = 12'h000;
`else
   localparam logic [11:0] EDGE = BODY;
`endif
   localparam int EW = 16 + 12 + 26;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [10:0] hcount_in = '0, vcount_in = '0, xpos = '0, ypos = '0;
   logic        hsync_in = 1'b0, hblnk_in = 1'b0, vsync_in = 1'b0, vblnk_in = 1'b0;
   logic        pos_valid = 1'b0;
   logic [11:0] rgb_in = '0;
   logic [10:0] hcount_out, vcount_out;
   logic        hsync_out, hblnk_out, vsync_out, vblnk_out, pos_pending;
   logic [11:0] rgb_out;

   logic [EW-1:0] exp_q[$];
   logic [15:0]   step_id = '0;
   logic          pv_next = 1'b0;
   logic [10:0]   px_next = '0, py_next = '0;
   int            checks = 0;
   int            errors = 0;

   draw_bird #(.FLAP_FRAMES(2)) dut (
      .clk(clk), .rst(rst),
      .hcount_in(hcount_in), .vcount_in(vcount_in),
      .hsync_in(hsync_in), .hblnk_in(hblnk_in), .vsync_in(vsync_in), .vblnk_in(vblnk_in),
      .rgb_in(rgb_in), .xpos(xpos), .ypos(ypos), .pos_valid(pos_valid),
      .hcount_out(hcount_out), .vcount_out(vcount_out),
      .hsync_out(hsync_out), .hblnk_out(hblnk_out), .vsync_out(vsync_out), .vblnk_out(vblnk_out),
      .rgb_out(rgb_out), .pos_pending(pos_pending)
   );

   // clock / reset
   always #5 clk = ~clk;

   // driver tasks
   task automatic step(input logic [10:0] h, input logic [10:0] v, input logic hb,
                       input logic vb, input logic [11:0] rgb, input logic [11:0] exp_rgb);
      @(posedge clk); #1;
      hcount_in = h;  vcount_in = v;  hblnk_in = hb;  vblnk_in = vb;  rgb_in = rgb;
      hsync_in  = 1'($urandom_range(0, 1));
      vsync_in  = 1'($urandom_range(0, 1));
      pos_valid = pv_next;  xpos = px_next;  ypos = py_next;  pv_next = 1'b0;
      step_id   = step_id + 16'd1;
      exp_q.push_back({step_id, exp_rgb, h, v, hsync_in, hb, vsync_in, vb});
   endtask

   task automatic pix(input int h, input int v, input logic [11:0] rgb, input logic [11:0] exp_rgb);
      step(11'(h), 11'(v), 1'b0, 1'b0, rgb, exp_rgb);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(11'd1600, 11'd300, 1'b1, 1'b0, 12'h123, 12'h123);
   endtask

   task automatic request(input int x, input int y);
      pv_next = 1'b1;  px_next = 11'(x);  py_next = 11'(y);
      idle(1);
   endtask

   // Blank rise; optional pos_valid lands on the exact rising cycle
   task automatic frame_boundary(input logic collide, input int x, input int y);
      idle(1);
      if (collide) begin
         pv_next = 1'b1;  px_next = 11'(x);  py_next = 11'(y);
      end
      for (int i = 0; i < 3; i++) step(11'd1600, 11'd610, 1'b1, 1'b1, 12'h456, 12'h456);
      step(11'd1600, 11'd0, 1'b1, 1'b0, 12'h456, 12'h456);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", name, act, exp);
      end
   endtask

   task automatic do_reset(input int n);
      @(posedge clk); #1;
      rst = 1'b1;  rgb_in = 12'hABC;  hcount_in = 11'd77;  vblnk_in = 1'b0;
      exp_q.delete();
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         chk("reset_rgb", 32'(rgb_out), 32'h0);
         chk("reset_pending", 32'(pos_pending), 32'h0);
         chk("reset_timing", 32'({hcount_out, vcount_out, hsync_out, hblnk_out, vsync_out, vblnk_out}), 32'h0);
      end
      rst = 1'b0;
   endtask

   // scoreboard monitor: output lags the push by two clock edges
   always @(negedge clk) begin
      if (!rst && exp_q.size() >= 3) begin
         logic [EW-1:0] e;
         e = exp_q.pop_front();
         checks++;
         if ({hcount_out, vcount_out, hsync_out, hblnk_out, vsync_out, vblnk_out} !== e[25:0]) begin
            errors++;
            $display("FAIL timing step=%0d got=%h exp=%h", e[53:38],
                     {hcount_out, vcount_out, hsync_out, hblnk_out, vsync_out, vblnk_out}, e[25:0]);
         end
         checks++;
         if (rgb_out !== e[37:26]) begin
            errors++;
            $display("FAIL rgb step=%0d h=%0d v=%0d got=%h exp=%h", e[53:38], e[25:15], e[14:4],
                     rgb_out, e[37:26]);
         end
      end
   end

   initial begin
      do_reset(3);
      idle(2);

      // Park the bird off-screen, then pass-through
      request(1900, 700);
      idle(1);
      chk("pending_set_offscreen", 32'(pos_pending), 32'h1);
      frame_boundary(1'b0, 0, 0);
      chk("pending_clear_b1", 32'(pos_pending), 32'h0);
      for (int i = 0; i < 6; i++) pix(100 + i * 7, 300 + i, 12'h0AF, 12'h0AF);
      pix(1899, 700, 12'h0AF, 12'h0AF);

      // Move to (100,300); wing is up after the second boundary
      request(100, 300);
      frame_boundary(1'b0, 0, 0);
      pix(100, 300, 12'h0AF, EDGE);
      pix(133, 323, 12'h0AF, EDGE);
      pix(101, 301, 12'h0AF, BODY);
      pix(134, 300, 12'h0AF, 12'h0AF);
      pix(100, 324, 12'h0AF, 12'h0AF);
      pix(99, 300, 12'h0AF, 12'h0AF);
      pix(100, 299, 12'h0AF, 12'h0AF);
      pix(105, 312, 12'h0AF, WING);
      pix(104, 310, 12'h0AF, WING);
      pix(113, 315, 12'h0AF, WING);
      pix(103, 312, 12'h0AF, BODY);
      pix(114, 312, 12'h0AF, BODY);
      pix(105, 316, 12'h0AF, BODY);
      step(11'd105, 11'd312, 1'b1, 1'b0, 12'h0AF, 12'h0AF);

      // Deferred update: current frame stays at (100,300)
      request(200, 200);
      idle(1);
      chk("pending_deferred", 32'(pos_pending), 32'h1);
      pix(100, 300, 12'h321, EDGE);
      pix(200, 200, 12'h321, 12'h321);
      frame_boundary(1'b0, 0, 0);
      chk("pending_clear_b3", 32'(pos_pending), 32'h0);
      pix(200, 200, 12'h321, EDGE);
      pix(100, 300, 12'h321, 12'h321);
      pix(205, 212, 12'h321, WING);

      // Collision: a stale pending value loses to the same-cycle request
      request(900, 900);
      idle(1);
      chk("pending_before_collide", 32'(pos_pending), 32'h1);
      frame_boundary(1'b1, 300, 400);
      chk("pending_after_collide", 32'(pos_pending), 32'h0);
      pix(300, 400, 12'h0F0, EDGE);
      pix(305, 412, 12'h0F0, BODY);
      pix(200, 200, 12'h0F0, 12'h0F0);
      pix(900, 900, 12'h0F0, 12'h0F0);

      // Flap cadence: wing down, down, then up again
      frame_boundary(1'b0, 0, 0);
      pix(305, 412, 12'h0F0, BODY);
      frame_boundary(1'b0, 0, 0);
      pix(305, 412, 12'h0F0, WING);

      // Last request before the boundary wins
      request(10, 10);
      request(20, 20);
      frame_boundary(1'b0, 0, 0);
      pix(20, 20, 12'h00F, EDGE);
      pix(25, 32, 12'h00F, WING);
      pix(10, 10, 12'h00F, 12'h00F);

      // Clip: bird at column 2040 must not wrap into columns 0..30
      request(2040, 5);
      frame_boundary(1'b0, 0, 0);
      for (int h = 0; h <= 30; h++) pix(h, 5 + (h % 6), 12'h5A5, 12'h5A5);
      pix(2040, 5, 12'h5A5, EDGE);
      pix(2047, 10, 12'h5A5, BODY);

      // Reset mid-line discards the pending position and returns to (0,0)
      request(50, 50);
      idle(1);
      chk("pending_before_reset", 32'(pos_pending), 32'h1);
      pix(2045, 8, 12'h5A5, BODY);
      do_reset(1);
      idle(2);
      chk("pending_after_reset", 32'(pos_pending), 32'h0);
      frame_boundary(1'b0, 0, 0);
      chk("pending_still_clear", 32'(pos_pending), 32'h0);
      pix(0, 0, 12'h777, EDGE);
      pix(5, 12, 12'h777, BODY);
      pix(50, 50, 12'h777, 12'h777);
      pix(34, 0, 12'h777, 12'h777);

      idle(4);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
